core_mem_arb: RTL and testbench

Single-port memory arbiter/sequencer that shares one memory interface between the instruction-fetch requester (IFU) and the EX-stage load/store unit (LSU). It accepts one request at a time, drives it onto the memory port with a valid/ready handshake, and routes the response back to the requester that owns the transaction. The LSU has fixed priority, and a starvation counter bounds IFU wait time. A pipeline flush from commit discards an in-flight fetch response.

---
 rtl/core_mem_arb_pkg.sv | 15 +
 rtl/core_mem_arb_age.sv | 30 +++
 rtl/gnrl_dfflr.sv | 25 ++
 rtl/core_mem_arb.sv | 152 +++++++++++++++
 tb/tb_core_mem_arb.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/core_mem_arb_pkg.sv
// Shared encodings for the core memory arbiter: FSM states and transaction owner.
package core_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_LSU = 1'b0,
    OWNER_IFU = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/core_mem_arb_age.sv
// Saturating IFU starvation counter; force_ifu is raised once the IFU has lost MAX_WAIT times in a row.
module core_mem_arb_age #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cnt_inc,
  input  logic cnt_clr,
  output logic force_ifu
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic [CW-1:0] age_r;

  // Count IFU losses, clear takes priority, hold at MAX_CNT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_r <= {CW{1'b0}};
    end else if (cnt_clr) begin
      age_r <= {CW{1'b0}};
    end else if (cnt_inc && (age_r != MAX_CNT)) begin
      age_r <= age_r + CW'(1);
    end
  end

  assign force_ifu = (age_r == MAX_CNT);

endmodule

// File: rtl/gnrl_dfflr.sv
// Generic load-enabled flop bank with asynchronous active-low reset to zero.
module gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  logic [DW-1:0] qout_r;

  // Capture dnxt when lden is high, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout_r <= {DW{1'b0}};
    end else if (lden) begin
      qout_r <= dnxt;
    end
  end

  assign qout = qout_r;

endmodule

// File: rtl/core_mem_arb.sv
// Single-port memory arbiter between IFU and LSU: one outstanding transaction,
// LSU priority with bounded IFU starvation, flush discards an in-flight fetch response.
module core_mem_arb
  import core_mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 64,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_req_addr,
  output logic            ifu_rsp_valid,
  input  logic            ifu_rsp_ready,
  output logic [DW-1:0]   ifu_rsp_data,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_req_addr,
  input  logic            lsu_req_wen,
  input  logic [DW-1:0]   lsu_req_wdata,
  input  logic [DW/8-1:0] lsu_req_wmask,
  output logic            lsu_rsp_valid,
  input  logic            lsu_rsp_ready,
  output logic [DW-1:0]   lsu_rsp_data,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_req_addr,
  output logic            mem_req_wen,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wmask,
  input  logic            mem_rsp_valid,
  output logic            mem_rsp_ready,
  input  logic [DW-1:0]   mem_rsp_data,
  input  logic            flush
);

  localparam int HW = AW + 1 + DW + DW / 8;

  arb_state_e state_r, state_nxt_s;
  arb_owner_e owner_r;
  logic       discard_r;
  logic       force_ifu_s, ifu_win_s, lsu_win_s, grant_s;
  logic       flush_ifu_s, discard_s, rsp_ready_s, rsp_fire_s;
  logic [HW-1:0] hold_nxt_s, hold_q_s;

  core_mem_arb_age #(.MAX_WAIT(MAX_WAIT)) u_age (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt_inc   (lsu_win_s & ifu_req_valid),
    .cnt_clr   (ifu_win_s | ~ifu_req_valid),
    .force_ifu (force_ifu_s)
  );

  // Grant, flush qualification, handshake outputs and next state.
  always_comb begin
    ifu_win_s     = 1'b0;
    lsu_win_s     = 1'b0;
    rsp_ready_s   = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    state_nxt_s   = state_r;
    flush_ifu_s   = flush & (owner_r == OWNER_IFU) & (state_r != ST_IDLE);
    discard_s     = discard_r | flush_ifu_s;
    // rst_n gating keeps both readys low while reset is held.
    if (rst_n && (state_r == ST_IDLE)) begin
      ifu_win_s = ifu_req_valid & ~flush & (~lsu_req_valid | force_ifu_s);
      lsu_win_s = lsu_req_valid & ~ifu_win_s;
    end else begin
      ifu_win_s = 1'b0;
    end
    grant_s = ifu_win_s | lsu_win_s;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_nxt_s = ST_RSP;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_RSP: begin
        if (discard_s) begin
          rsp_ready_s = 1'b1;
        end else if (owner_r == OWNER_IFU) begin
          rsp_ready_s   = ifu_rsp_ready;
          ifu_rsp_valid = mem_rsp_valid;
        end else begin
          rsp_ready_s   = lsu_rsp_ready;
          lsu_rsp_valid = mem_rsp_valid;
        end
        if (mem_rsp_valid && rsp_ready_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RSP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    rsp_fire_s = (state_r == ST_RSP) & mem_rsp_valid & rsp_ready_s;
  end

  // State, owner and discard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      owner_r   <= OWNER_LSU;
      discard_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        owner_r <= ifu_win_s ? OWNER_IFU : OWNER_LSU;
      end
      if (rsp_fire_s) begin
        discard_r <= 1'b0;
      end else if (flush_ifu_s) begin
        discard_r <= 1'b1;
      end
    end
  end

  // Fetches never write: wen, wdata and wmask are forced to zero on an IFU grant.
  assign hold_nxt_s = ifu_win_s
                    ? {ifu_req_addr, 1'b0, {DW{1'b0}}, {(DW/8){1'b0}}}
                    : {lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask};

  gnrl_dfflr #(.DW(HW)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .lden  (grant_s),
    .dnxt  (hold_nxt_s),
    .qout  (hold_q_s)
  );

  assign {mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} = hold_q_s;
  assign mem_req_valid = (state_r == ST_REQ);
  assign mem_rsp_ready = rsp_ready_s;
  assign ifu_req_ready = ifu_win_s;
  assign lsu_req_ready = lsu_win_s;
  assign ifu_rsp_data  = mem_rsp_data;
  assign lsu_rsp_data  = mem_rsp_data;

endmodule

// File: tb/tb_core_mem_arb.sv
// Directed self-checking bench for core_mem_arb: inputs driven and outputs sampled just after each falling edge.
module tb_core_mem_arb;

  localparam int AW = 32;
  localparam int DW = 64;

  logic            clk, rst_n, flush;
  logic            ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [AW-1:0]   ifu_req_addr;
  logic [DW-1:0]   ifu_rsp_data;
  logic            lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_ready;
  logic [AW-1:0]   lsu_req_addr;
  logic [DW-1:0]   lsu_req_wdata, lsu_rsp_data;
  logic [DW/8-1:0] lsu_req_wmask;
  logic            mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, mem_rsp_ready;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_wdata, mem_rsp_data;
  logic [DW/8-1:0] mem_req_wmask;

  int n_cmp = 0;
  int n_err = 0;

  core_mem_arb #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_data(ifu_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    flush = 1'b0; ifu_req_valid = 1'b0; ifu_req_addr = 32'h0; ifu_rsp_ready = 1'b1;
    lsu_req_valid = 1'b0; lsu_req_addr = 32'h0; lsu_req_wen = 1'b0;
    lsu_req_wdata = 64'h0; lsu_req_wmask = 8'h00; lsu_rsp_ready = 1'b1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 64'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; mem_rsp_valid = 1'b1;
    #1;
    n_cmp++; if (ifu_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ifu_req_ready: got %b exp 0", ifu_req_ready); end
    n_cmp++; if (lsu_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_lsu_req_ready: got %b exp 0", lsu_req_ready); end
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_mem_req_valid: got %b exp 0", mem_req_valid); end
    n_cmp++; if (mem_rsp_ready !== 1'b0) begin n_err++; $display("FAIL rst_mem_rsp_ready: got %b exp 0", mem_rsp_ready); end
    n_cmp++; if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin n_err++; $display("FAIL rst_rsp_valid: got %b exp 00", {ifu_rsp_valid, lsu_rsp_valid}); end
    n_cmp++; if (mem_req_addr !== 32'h0) begin n_err++; $display("FAIL rst_hold_addr: got %h exp 0", mem_req_addr); end
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_lsu_load();
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0010; lsu_req_wen = 1'b0;
    #1;
    n_cmp++; if (lsu_req_ready !== 1'b1) begin n_err++; $display("FAIL load_lsu_ready: got %b exp 1", lsu_req_ready); end
    n_cmp++; if (ifu_req_ready !== 1'b0) begin n_err++; $display("FAIL load_ifu_ready: got %b exp 0", ifu_req_ready); end
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL load_mem_valid_T: got %b exp 0", mem_req_valid); end
    @(negedge clk);
    lsu_req_valid = 1'b0; lsu_req_addr = 32'h0; mem_req_ready = 1'b1;
    #1;
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL load_mem_valid_T1: got %b exp 1", mem_req_valid); end
    n_cmp++; if (mem_req_addr !== 32'h8000_0010) begin n_err++; $display("FAIL load_mem_addr: got %h exp 80000010", mem_req_addr); end
    n_cmp++; if (mem_req_wen !== 1'b0) begin n_err++; $display("FAIL load_mem_wen: got %b exp 0", mem_req_wen); end
    @(negedge clk);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h1122_3344_5566_7788;
    #1;
    n_cmp++; if (lsu_rsp_valid !== 1'b1) begin n_err++; $display("FAIL load_rsp_valid: got %b exp 1", lsu_rsp_valid); end
    n_cmp++; if (lsu_rsp_data !== 64'h1122_3344_5566_7788) begin n_err++; $display("FAIL load_rsp_data: got %h exp 1122334455667788", lsu_rsp_data); end
    n_cmp++; if (ifu_rsp_valid !== 1'b0) begin n_err++; $display("FAIL load_ifu_rsp_valid: got %b exp 0", ifu_rsp_valid); end
    n_cmp++; if (mem_rsp_ready !== 1'b1) begin n_err++; $display("FAIL load_mem_rsp_ready: got %b exp 1", mem_rsp_ready); end
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if ({mem_req_valid, lsu_rsp_valid, mem_rsp_ready} !== 3'b000) begin n_err++; $display("FAIL load_idle_after: got %b exp 000", {mem_req_valid, lsu_rsp_valid, mem_rsp_ready}); end
  endtask

  task automatic test_priority();
    logic [9:0] exp_ifu;
    exp_ifu = 10'b10000_10000;  // bit i: 1 = IFU wins transaction i (LSB first)
    ifu_req_addr = 32'h0000_1000; lsu_req_addr = 32'h0000_2000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mem_rsp_valid = 1'b0; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
      #1;
      n_cmp++; if ({ifu_req_ready, lsu_req_ready} !== {exp_ifu[i], ~exp_ifu[i]}) begin n_err++; $display("FAIL prio_grant[%0d]: got ifu/lsu %b%b exp %b%b", i, ifu_req_ready, lsu_req_ready, exp_ifu[i], ~exp_ifu[i]); end
      @(negedge clk);
      mem_req_ready = 1'b1;
      #1;
      n_cmp++; if (mem_req_addr !== (exp_ifu[i] ? 32'h0000_1000 : 32'h0000_2000)) begin n_err++; $display("FAIL prio_addr[%0d]: got %h", i, mem_req_addr); end
      @(negedge clk);
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'(i);
      #1;
      n_cmp++; if ({ifu_rsp_valid, lsu_rsp_valid} !== {exp_ifu[i], ~exp_ifu[i]}) begin n_err++; $display("FAIL prio_rsp[%0d]: got ifu/lsu %b%b exp %b%b", i, ifu_rsp_valid, lsu_rsp_valid, exp_ifu[i], ~exp_ifu[i]); end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_flush_req();
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; ifu_rsp_ready = 1'b0;
    #1;
    n_cmp++; if (ifu_req_ready !== 1'b1) begin n_err++; $display("FAIL flush_ifu_grant: got %b exp 1", ifu_req_ready); end
    @(negedge clk);
    ifu_req_valid = 1'b0; flush = 1'b1;
    #1;
    n_cmp++; if ({mem_req_valid, mem_req_wen, mem_req_wmask} !== 10'b1_0_00000000) begin n_err++; $display("FAIL flush_req_fields: got %b exp 1000000000", {mem_req_valid, mem_req_wen, mem_req_wmask}); end
    n_cmp++; if (mem_req_addr !== 32'h8000_0000) begin n_err++; $display("FAIL flush_req_addr: got %h exp 80000000", mem_req_addr); end
    @(negedge clk);
    flush = 1'b0; mem_req_ready = 1'b1;
    #1;
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL flush_req_hold: got %b exp 1", mem_req_valid); end
    @(negedge clk);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'hDEAD;
    #1;
    n_cmp++; if (mem_rsp_ready !== 1'b1) begin n_err++; $display("FAIL flush_mem_rsp_ready: got %b exp 1", mem_rsp_ready); end
    n_cmp++; if (ifu_rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_ifu_rsp_valid: got %b exp 0", ifu_rsp_valid); end
    @(negedge clk);
    mem_rsp_valid = 1'b0; ifu_rsp_ready = 1'b1; lsu_req_valid = 1'b1;
    #1;
    n_cmp++; if ({lsu_req_ready, ifu_rsp_valid} !== 2'b10) begin n_err++; $display("FAIL flush_idle_next: got %b exp 10", {lsu_req_ready, ifu_rsp_valid}); end
    lsu_req_valid = 1'b0;
  endtask

  task automatic test_flush_last_beat();
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0100;
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'hBEEF; flush = 1'b1;
    #1;
    n_cmp++; if ({ifu_rsp_valid, mem_rsp_ready} !== 2'b01) begin n_err++; $display("FAIL lastbeat_discard: got %b exp 01", {ifu_rsp_valid, mem_rsp_ready}); end
    @(negedge clk);
    drive_idle();
    lsu_req_valid = 1'b1;
    #1;
    n_cmp++; if ({lsu_req_ready, ifu_rsp_valid} !== 2'b10) begin n_err++; $display("FAIL lastbeat_idle: got %b exp 10", {lsu_req_ready, ifu_rsp_valid}); end
    lsu_req_valid = 1'b0;
  endtask

  task automatic test_store_stall();
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0020; lsu_req_wen = 1'b1;
    lsu_req_wdata = 64'hFF; lsu_req_wmask = 8'h01;
    #1;
    n_cmp++; if (lsu_req_ready !== 1'b1) begin n_err++; $display("FAIL store_grant: got %b exp 1", lsu_req_ready); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      lsu_req_valid = 1'b0; lsu_req_addr = 32'hAAAA_AAAA; lsu_req_wen = 1'b0;
      lsu_req_wdata = 64'h5555; lsu_req_wmask = 8'hF0; mem_req_ready = (c == 3);
      #1;
      n_cmp++; if ({mem_req_valid, mem_req_wen, mem_req_wmask, mem_req_addr, mem_req_wdata} !== {1'b1, 1'b1, 8'h01, 32'h8000_0020, 64'hFF})
        begin n_err++; $display("FAIL store_stable[%0d]: got v%b w%b m%h a%h d%h", c, mem_req_valid, mem_req_wen, mem_req_wmask, mem_req_addr, mem_req_wdata); end
    end
    @(negedge clk);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; flush = 1'b1;
    #1;
    n_cmp++; if ({lsu_rsp_valid, mem_rsp_ready, ifu_rsp_valid} !== 3'b110) begin n_err++; $display("FAIL store_ack: got %b exp 110", {lsu_rsp_valid, mem_rsp_ready, ifu_rsp_valid}); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_rsp_backpressure();
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0030;
    @(negedge clk);
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h77; lsu_rsp_ready = (c == 2);
      #1;
      n_cmp++; if ({lsu_rsp_valid, mem_rsp_ready} !== {1'b1, (c == 2)}) begin n_err++; $display("FAIL bp_cycle[%0d]: got %b%b exp 1%b", c, lsu_rsp_valid, mem_rsp_ready, (c == 2)); end
    end
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if ({lsu_rsp_valid, mem_rsp_ready} !== 2'b00) begin n_err++; $display("FAIL bp_done: got %b exp 00", {lsu_rsp_valid, mem_rsp_ready}); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0080;
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h1234;
    #1;
    n_cmp++; if (ifu_rsp_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre: got %b exp 1", ifu_rsp_valid); end
    rst_n = 1'b0; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #1;
    n_cmp++; if ({ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready, mem_req_valid, ifu_req_ready, lsu_req_ready} !== 6'b0)
      begin n_err++; $display("FAIL midrst_outputs: got %b exp 000000", {ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready, mem_req_valid, ifu_req_ready, lsu_req_ready}); end
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0040;
    #1;
    n_cmp++; if ({ifu_req_ready, ifu_rsp_valid} !== 2'b10) begin n_err++; $display("FAIL midrst_regrant: got %b exp 10", {ifu_req_ready, ifu_rsp_valid}); end
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    #1;
    n_cmp++; if (mem_req_addr !== 32'h8000_0040) begin n_err++; $display("FAIL midrst_addr: got %h exp 80000040", mem_req_addr); end
    @(negedge clk);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'hCAFE_F00D_0000_0001;
    #1;
    n_cmp++; if (ifu_rsp_data !== 64'hCAFE_F00D_0000_0001 || ifu_rsp_valid !== 1'b1) begin n_err++; $display("FAIL midrst_rsp: got v%b d%h exp v1 dcafef00d00000001", ifu_rsp_valid, ifu_rsp_data); end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_lsu_load();
    test_priority();
    test_flush_req();
    test_flush_last_beat();
    test_store_stall();
    test_rsp_backpressure();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
